// File: rtl/reset_request_ctrl.sv
// Reset request front end: merges button, software and watchdog reset sources into a
// single-cycle request, then follows the generated pulse through rise, fall and holdoff.
module reset_request_ctrl #(
  parameter int DEBOUNCE    = 1000,
  parameter int WD_TIMEOUT  = 1000000,
  parameter int HOLDOFF     = 100,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       async_reset_i,
  input  logic       button_i,
  input  logic       soft_req_i,
  input  logic       wd_enable_i,
  input  logic       wd_kick_i,
  input  logic       rst_pulse_i,
  output logic       reset_req_o,
  output logic [2:0] cause_o,
  input  logic       cause_clr_i,
  output logic       ack_err_o,
  output logic       busy_o
);

  localparam int              DB_W      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [31:0]     WD_LAST   = 32'(WD_TIMEOUT - 1);
  localparam logic [31:0]     ACK_LAST  = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0]     HOLD_LAST = 32'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_HIGH,
    S_WAIT_LOW,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            sync_meta;
  logic            sync_btn;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic [31:0]     wd_cnt;
  logic [31:0]     cnt;
  logic            btn_req;
  logic            wd_expire;
  logic [2:0]      new_cause;
  logic            any_req;
  logic            timeout;

  // The debounced level keeps tracking the button even while busy, so a held
  // button produces exactly one rising edge and cannot re-trigger later.
  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      sync_meta <= 1'b0;
      sync_btn  <= 1'b0;
      db_level  <= 1'b0;
      db_prev   <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_meta <= button_i;
      sync_btn  <= sync_meta;
      db_prev   <= db_level;
      if (sync_btn == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      wd_cnt <= '0;
    end else if (!wd_enable_i || wd_kick_i || state != S_IDLE) begin
      wd_cnt <= '0;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign btn_req   = db_level & ~db_prev;
  assign wd_expire = (state == S_IDLE) && wd_enable_i && (wd_cnt == WD_LAST);
  assign new_cause = {wd_expire, soft_req_i, btn_req};
  assign any_req   = |new_cause;

  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == S_IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) state_next = S_REQ;
      end
      S_REQ: begin
        state_next = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (rst_pulse_i) begin
          state_next = S_WAIT_LOW;
        end else if (cnt == ACK_LAST) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_LOW: begin
        if (!rst_pulse_i) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state; a clear coinciding with a
  // trigger is applied before the new cause bits are merged in.
  always_ff @(posedge clk or posedge async_reset_i) begin
    if (async_reset_i) begin
      reset_req_o <= 1'b0;
      busy_o      <= 1'b0;
      cause_o     <= '0;
      ack_err_o   <= 1'b0;
    end else begin
      reset_req_o <= (state_next == S_REQ);
      busy_o      <= (state_next != S_IDLE);
      if (state == S_IDLE && any_req) begin
        cause_o <= (cause_clr_i ? 3'b000 : cause_o) | new_cause;
      end else if (cause_clr_i) begin
        cause_o <= 3'b000;
      end
      ack_err_o <= (cause_clr_i ? 1'b0 : ack_err_o) | timeout;
    end
  end

endmodule
